// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - state/lamp encodings and phase duration lookup (optional TRAFFIC_LIGHT_NIGHT_FLASH_EN adds FLASH)
package traffic_light_pkg;

`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        FLASH       = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;
`endif

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    // Phase length in ticks; FLASH is not timed, so any nonzero value works
    function automatic int state_dur(input state_t s, input int t_main, input int t_yel,
                                     input int t_ar, input int t_sg);
        case (s)
            MAIN_GREEN:               return t_main;
            MAIN_YELLOW, SIDE_YELLOW: return t_yel;
            ALL_RED_A, ALL_RED_B:     return t_ar;
            SIDE_GREEN:               return t_sg;
            default:                  return 1;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - tick-driven phase down-counter with load and zero flag
module tl_phase_timer #(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over counting; the count only moves on ticks and parks at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road intersection sequencer with pedestrian walk (optional TRAFFIC_LIGHT_NIGHT_FLASH_EN)
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int T_MAIN_MIN   = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_SIDE_GREEN = 6,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       ped_walk,
    output logic [2:0] phase
);

    state_t           state_q;
    state_t           next_state;
    logic             timer_zero;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             side_pend;
    logic             ped_pend;
    logic             walk_flag;
    logic             entering_sg;
    logic             side_pend_d;
    logic             ped_pend_d;
    logic             walk_flag_d;
    logic [2:0]       main_lamp_d;
    logic [2:0]       side_lamp_d;
    logic             ped_walk_d;
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
    logic             blink;
    logic             blink_d;
`endif

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_MAIN_MIN - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (tick),
        .zero     (timer_zero)
    );

    // Next state, timer reload, request bookkeeping and next lamp values
    always_comb begin
        next_state = state_q;
        case (state_q)
            MAIN_GREEN: begin
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
                if (tick && timer_zero && (night || side_pend || ped_pend))
                    next_state = MAIN_YELLOW;
`else
                if (tick && timer_zero && (side_pend || ped_pend))
                    next_state = MAIN_YELLOW;
`endif
            end
            MAIN_YELLOW: if (tick && timer_zero) next_state = ALL_RED_A;
            ALL_RED_A: begin
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
                if (tick && timer_zero) next_state = night ? FLASH : SIDE_GREEN;
`else
                if (tick && timer_zero) next_state = SIDE_GREEN;
`endif
            end
            SIDE_GREEN:  if (tick && timer_zero) next_state = SIDE_YELLOW;
            SIDE_YELLOW: if (tick && timer_zero) next_state = ALL_RED_B;
            ALL_RED_B:   if (tick && timer_zero) next_state = MAIN_GREEN;
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
            FLASH:       if (tick && !night) next_state = ALL_RED_B;
`endif
            // Unknown encodings recover through a red clearance phase
            default:     next_state = ALL_RED_B;
        endcase

        // Every transition changes state, so a change is exactly a phase entry
        timer_load     = (next_state != state_q);
        timer_load_val = CNT_W'(state_dur(next_state, T_MAIN_MIN, T_YELLOW,
                                          T_ALL_RED, T_SIDE_GREEN) - 1);

        // Requests on the serving edge count as served
        entering_sg = timer_load && (next_state == SIDE_GREEN);
        side_pend_d = entering_sg ? 1'b0 : (side_pend | side_req);
        ped_pend_d  = entering_sg ? 1'b0 : (ped_pend | ped_req);
        walk_flag_d = entering_sg ? (ped_pend | ped_req) : walk_flag;

`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
        blink_d = blink;
        if (timer_load && (next_state == FLASH))
            blink_d = 1'b1;
        else if ((state_q == FLASH) && tick)
            blink_d = ~blink;
`endif

        main_lamp_d = LAMP_RED;
        side_lamp_d = LAMP_RED;
        ped_walk_d  = 1'b0;
        case (next_state)
            MAIN_GREEN:  main_lamp_d = LAMP_GREEN;
            MAIN_YELLOW: main_lamp_d = LAMP_YELLOW;
            SIDE_GREEN: begin
                side_lamp_d = LAMP_GREEN;
                ped_walk_d  = walk_flag_d;
            end
            SIDE_YELLOW: side_lamp_d = LAMP_YELLOW;
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
            FLASH: begin
                main_lamp_d = blink_d ? LAMP_YELLOW : LAMP_OFF;
                side_lamp_d = blink_d ? LAMP_RED : LAMP_OFF;
            end
`endif
            default: ;
        endcase
    end

    // State, request latches and registered lamp outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MAIN_GREEN;
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
            walk_flag <= 1'b0;
            main_lamp <= LAMP_GREEN;
            side_lamp <= LAMP_RED;
            ped_walk  <= 1'b0;
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
            blink     <= 1'b1;
`endif
        end else begin
            state_q   <= next_state;
            side_pend <= side_pend_d;
            ped_pend  <= ped_pend_d;
            walk_flag <= walk_flag_d;
            main_lamp <= main_lamp_d;
            side_lamp <= side_lamp_d;
            ped_walk  <= ped_walk_d;
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
            blink     <= blink_d;
`endif
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - randomized and directed check of traffic_light_ctrl against a phase model
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       ped_walk;
    logic [2:0] phase;
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    traffic_light_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .side_req  (side_req),
        .ped_req   (ped_req),
`ifdef TRAFFIC_LIGHT_NIGHT_FLASH_EN
        .night     (night),
`endif
        .main_lamp (main_lamp),
        .side_lamp (side_lamp),
        .ped_walk  (ped_walk),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase index, ticks seen in phase, and pending requests
    int dur [6] = '{10, 3, 1, 6, 3, 1};
    int mp = 0;
    int mcnt = 0;
    int np = 0;
    bit msp = 0, mpp = 0, mwalk = 0, mvalid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mp = 0; mcnt = 0; msp = 0; mpp = 0; mwalk = 0; mvalid = 1;
        end else if (mvalid) begin
            np = mp;
            if (tick) begin
                if ((mcnt + 1 >= dur[mp]) && (mp != 0 || msp || mpp)) begin
                    np = (mp + 1) % 6;
                    mcnt = 0;
                end else if (mcnt + 1 < dur[mp]) begin
                    mcnt = mcnt + 1;
                end
            end
            if (np == 3 && mp != 3) begin
                mwalk = mpp | ped_req;
                msp = 0;
                mpp = 0;
            end else begin
                msp = msp | side_req;
                mpp = mpp | ped_req;
            end
            mp = np;
        end
    end

    // Compare every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (mvalid) begin
            chk("main_lamp", {5'd0, main_lamp},
                {5'd0, (mp == 0) ? 3'b001 : (mp == 1) ? 3'b010 : 3'b100});
            chk("side_lamp", {5'd0, side_lamp},
                {5'd0, (mp == 3) ? 3'b001 : (mp == 4) ? 3'b010 : 3'b100});
            chk("ped_walk", {7'd0, ped_walk}, {7'd0, (mp == 3) && mwalk});
            chk("phase", {5'd0, phase}, 8'(mp));
            chk("safety", {7'd0, (main_lamp != 3'b100) && (side_lamp != 3'b100)}, 8'd0);
            chk("onehot", {7'd0, $onehot(main_lamp) && $onehot(side_lamp)}, 8'd1);
        end
    end

    task automatic step(input logic t, input logic s, input logic p);
        tick = t;
        side_req = s;
        ped_req = p;
        @(negedge clk);
    endtask

    task automatic do_tick(input logic s, input logic p);
        step(1'b1, s, p);
        step(1'b0, s, p);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    int e;
    int n;

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_main", {5'd0, main_lamp}, 8'h01);
        chk("rst_side", {5'd0, side_lamp}, 8'h04);
        chk("rst_walk", {7'd0, ped_walk}, 8'h00);
        chk("rst_phase", {5'd0, phase}, 8'h00);

        // No requests: main green holds
        for (int i = 1; i <= 20; i++) begin
            do_tick(1'b0, 1'b0);
            chk("idle_phase", {5'd0, phase}, 8'h00);
            chk("idle_main", {5'd0, main_lamp}, 8'h01);
        end

        // Side request pulse at tick 2
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, i == 2, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            case (i)
                9: e = 0;  10: e = 1;  13: e = 2;  14: e = 3;
                20: e = 4; 23: e = 5;  24: e = 0;
                default: e = -1;
            endcase
            if (e >= 0) chk("side_seq_phase", {5'd0, phase}, 8'(e));
            if (i == 14) chk("side_seq_walk", {7'd0, ped_walk}, 8'h00);
        end

        // Pedestrian request after minimum green
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            if (i == 16) step(1'b0, 1'b0, 1'b1);
            do_tick(1'b0, 1'b0);
            case (i)
                15: e = 0; 16: e = 1; 19: e = 2; 20: e = 3; 25: e = 3; 26: e = 4;
                default: e = -1;
            endcase
            if (e >= 0) chk("ped_seq_phase", {5'd0, phase}, 8'(e));
            if (i >= 20 && i <= 25) chk("ped_seq_walk", {7'd0, ped_walk}, 8'h01);
        end

        // Side request held: main green lasts exactly T_MAIN_MIN ticks each cycle
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (phase == 3'd0 && n < 50) begin
                do_tick(1'b1, 1'b0);
                n++;
            end
            chk("held_mg_len", 8'(n), 8'd10);
            n = 0;
            while (phase != 3'd0 && n < 50) begin
                do_tick(1'b1, 1'b0);
                n++;
            end
            chk("held_rest_len", 8'(n), 8'd14);
        end

        // Reset during side green with no tick
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, i == 2, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("pre_rst_phase", {5'd0, phase}, 8'h03);
        step(1'b0, 1'b1, 1'b1);
        do_reset();
        chk("mid_rst_main", {5'd0, main_lamp}, 8'h01);
        chk("mid_rst_side", {5'd0, side_lamp}, 8'h04);
        chk("mid_rst_walk", {7'd0, ped_walk}, 8'h00);
        for (int i = 1; i <= 15; i++) do_tick(1'b0, 1'b0);
        chk("pend_cleared", {5'd0, phase}, 8'h00);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 29) == 0);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
